nvdla_csb_sequencer: RTL and testbench

Command sequencer between the HWPE register-file/control path and the NVDLA CSB port. Software or the engine controller queues CSB commands (16-bit address, 32-bit write data, write flag, wait-for-interrupt flag). On `start_i` the block replays the queue on the CSB valid/ready interface in order and waits for each write completion or read response. After any command that carries the wait-for-interrupt flag, it also waits for the NVDLA interrupt, with an optional timeout. It removes per-register software round-trips when launching a layer.

---
 rtl/nvdla_csb_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_nvdla_csb_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_csb_sequencer.sv
// nvdla_csb_sequencer: queues CSB commands and replays them in order on the
// NVDLA CSB port. Each command waits for its write completion or read
// response, and optionally for the NVDLA interrupt (with a cycle limit).
module nvdla_csb_sequencer #(
    parameter int DEPTH     = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [15:0]          cmd_addr_i,
    input  logic [31:0]          cmd_wdat_i,
    input  logic                 cmd_write_i,
    input  logic                 cmd_wait_intr_i,
    input  logic                 start_i,
    input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
    output logic                 csb_valid_o,
    input  logic                 csb_ready_i,
    output logic [15:0]          csb_addr_o,
    output logic [31:0]          csb_wdat_o,
    output logic                 csb_write_o,
    output logic                 csb_nposted_o,
    input  logic                 csb_rdat_valid_i,
    input  logic [31:0]          csb_rdat_i,
    input  logic                 csb_wr_complete_i,
    input  logic                 intr_i,
    output logic [31:0]          rdata_o,
    output logic                 rdata_valid_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [15:0]          cmd_count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] wdat;
        logic        write;
        logic        wait_intr;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RESP, WAIT_INTR, DONE} state_t;

    cmd_t                 mem [DEPTH];
    cmd_t                 head;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_next;
    logic                 push;
    logic                 pop;
    logic                 flush;
    logic                 resp;
    state_t               state;
    logic                 wr_lat;
    logic                 wait_lat;
    logic [TIMEOUT_W-1:0] tcnt;

    assign head          = mem[rd_ptr];
    assign push          = cmd_valid_i && cmd_ready_o;
    assign pop           = csb_valid_o && csb_ready_i;
    assign resp          = wr_lat ? csb_wr_complete_i : csb_rdat_valid_i;
    assign csb_nposted_o = csb_write_o;
    // A timeout only counts when the interrupt is not present the same cycle.
    assign flush         = (state == WAIT_INTR) && !intr_i &&
                           (timeout_cycles_i != '0) && (tcnt == timeout_cycles_i);

    // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // FIFO storage; data is not reset, only the pointers and count are.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= '{cmd_addr_i, cmd_wdat_i, cmd_write_i, cmd_wait_intr_i};
        end
    end

    // FIFO pointers, count and the registered not-full flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cmd_ready_o <= 1'b0;
        end else if (clear_i || flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cmd_ready_o <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count       <= count_next;
            cmd_ready_o <= (count_next != FULL);
        end
    end

    // Sequencer FSM with all CSB and status outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            csb_valid_o   <= 1'b0;
            csb_addr_o    <= '0;
            csb_wdat_o    <= '0;
            csb_write_o   <= 1'b0;
            wr_lat        <= 1'b0;
            wait_lat      <= 1'b0;
            tcnt          <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            timeout_o     <= 1'b0;
            cmd_count_o   <= '0;
        end else if (clear_i) begin
            state         <= IDLE;
            csb_valid_o   <= 1'b0;
            csb_addr_o    <= '0;
            csb_wdat_o    <= '0;
            csb_write_o   <= 1'b0;
            wr_lat        <= 1'b0;
            wait_lat      <= 1'b0;
            tcnt          <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            timeout_o     <= 1'b0;
            cmd_count_o   <= '0;
        end else begin
            rdata_valid_o <= 1'b0;
            done_o        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (count != '0) begin
                            state       <= ISSUE;
                            csb_valid_o <= 1'b1;
                            csb_addr_o  <= head.addr;
                            csb_wdat_o  <= head.wdat;
                            csb_write_o <= head.write;
                            cmd_count_o <= '0;
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (csb_ready_i) begin
                        csb_valid_o <= 1'b0;
                        wr_lat      <= head.write;
                        wait_lat    <= head.wait_intr;
                        state       <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (resp) begin
                        if (cmd_count_o != 16'hFFFF) cmd_count_o <= cmd_count_o + 16'd1;
                        if (!wr_lat) begin
                            rdata_o       <= csb_rdat_i;
                            rdata_valid_o <= 1'b1;
                        end
                        if (wait_lat) begin
                            state <= WAIT_INTR;
                            tcnt  <= '0;
                        end else if (count != '0) begin
                            state       <= ISSUE;
                            csb_valid_o <= 1'b1;
                            csb_addr_o  <= head.addr;
                            csb_wdat_o  <= head.wdat;
                            csb_write_o <= head.write;
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                WAIT_INTR: begin
                    if (intr_i) begin
                        if (count != '0) begin
                            state       <= ISSUE;
                            csb_valid_o <= 1'b1;
                            csb_addr_o  <= head.addr;
                            csb_wdat_o  <= head.wdat;
                            csb_write_o <= head.write;
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end else if (flush) begin
                        timeout_o <= 1'b1;
                        state     <= DONE;
                        done_o    <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TIMEOUT_W'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nvdla_csb_sequencer.sv
// tb_nvdla_csb_sequencer: directed scenarios plus randomized runs, with a
// queue-based reference model of the command stream and a CSB slave model.
`timescale 1ns/1ps
module tb_nvdla_csb_sequencer;

    localparam int TIMEOUT_W = 16;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] wdat;
        logic        write;
        logic        wait_intr;
    } cmd_t;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 clear_i = 1'b0;
    logic                 cmd_valid_i = 1'b0;
    logic                 cmd_ready_o;
    logic [15:0]          cmd_addr_i = '0;
    logic [31:0]          cmd_wdat_i = '0;
    logic                 cmd_write_i = 1'b0;
    logic                 cmd_wait_intr_i = 1'b0;
    logic                 start_i = 1'b0;
    logic [TIMEOUT_W-1:0] timeout_cycles_i = '0;
    logic                 csb_valid_o;
    logic                 csb_ready_i = 1'b0;
    logic [15:0]          csb_addr_o;
    logic [31:0]          csb_wdat_o;
    logic                 csb_write_o;
    logic                 csb_nposted_o;
    logic                 csb_rdat_valid_i = 1'b0;
    logic [31:0]          csb_rdat_i = '0;
    logic                 csb_wr_complete_i = 1'b0;
    logic                 intr_i = 1'b0;
    logic [31:0]          rdata_o;
    logic                 rdata_valid_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 timeout_o;
    logic [15:0]          cmd_count_o;

    nvdla_csb_sequencer #(.DEPTH(8), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_wdat_i(cmd_wdat_i),
        .cmd_write_i(cmd_write_i), .cmd_wait_intr_i(cmd_wait_intr_i),
        .start_i(start_i), .timeout_cycles_i(timeout_cycles_i),
        .csb_valid_o(csb_valid_o), .csb_ready_i(csb_ready_i),
        .csb_addr_o(csb_addr_o), .csb_wdat_o(csb_wdat_o),
        .csb_write_o(csb_write_o), .csb_nposted_o(csb_nposted_o),
        .csb_rdat_valid_i(csb_rdat_valid_i), .csb_rdat_i(csb_rdat_i),
        .csb_wr_complete_i(csb_wr_complete_i), .intr_i(intr_i),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .busy_o(busy_o),
        .done_o(done_o), .timeout_o(timeout_o), .cmd_count_o(cmd_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state: commands the DUT should still hold, in order.
    cmd_t        exp_q[$];
    cmd_t        pend[$];
    int          exp_count = 0;
    logic        exp_timeout = 1'b0;
    int          tests = 0;
    int          fails = 0;

    // Slave/stimulus knobs (-1 = random where noted).
    int          cfg_resp_dly = 0;   // -1: random 0..4
    int          cfg_bp = 0;         // -1: random 0..3 stall cycles per request
    int          cfg_intr_dly = -1;  // -1: never, -2: random 0..6
    int          cfg_push_pct = 0;
    bit          cfg_noise = 1'b0;
    bit          cfg_rd_fixed = 1'b0;
    logic [31:0] cfg_rdat = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    function automatic int pick(input int cfg, input int hi);
        if (cfg < 0) return int'($urandom_range(0, hi));
        return cfg;
    endfunction

    function automatic cmd_t mk(input logic [15:0] a, input logic [31:0] d,
                                input logic w, input logic wi);
        mk = '{a, d, w, wi};
    endfunction

    function automatic cmd_t rnd_cmd();
        rnd_cmd = mk(16'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 3) == 0));
    endfunction

    // Push while the sequencer is idle; deferred to the mid-run list if full.
    task automatic push_idle(input cmd_t c);
        if (cmd_ready_o) begin
            cmd_addr_i = c.addr; cmd_wdat_i = c.wdat;
            cmd_write_i = c.write; cmd_wait_intr_i = c.wait_intr;
            cmd_valid_i = 1'b1;
            exp_q.push_back(c);
            tick();
            cmd_valid_i = 1'b0;
        end else begin
            pend.push_back(c);
        end
    endtask

    // Start a run and act as CSB slave / interrupt source until done_o.
    task automatic run_seq(input string nm);
        int phase, cnt, bp, k, budget, chk, cur_intr;
        bit chk_ne, hold, fin;
        cmd_t cur;
        logic [15:0] h_addr;
        logic [31:0] h_wdat, rd;
        phase = 0; cnt = 0; k = 0; budget = 0; cur_intr = -1;
        hold = 1'b0; fin = 1'b0; cur = '0; h_addr = '0; h_wdat = '0; rd = '0;
        chk = 1;
        chk_ne = (exp_q.size() != 0);
        if (chk_ne) exp_count = 0;
        bp = pick(cfg_bp, 3);
        start_i = 1'b1;
        while (!fin) begin
            tick();
            start_i = 1'b0; cmd_valid_i = 1'b0; csb_ready_i = 1'b0;
            csb_wr_complete_i = 1'b0; csb_rdat_valid_i = 1'b0; intr_i = 1'b0;
            budget++;
            if (budget > 2000) begin
                check({nm, " cycle budget"}, 32'(budget), 32'd2000);
                fin = 1'b1;
            end else begin
                if (hold) begin
                    check({nm, " valid held"}, 32'(csb_valid_o), 32'd1);
                    check({nm, " addr held"}, 32'(csb_addr_o), 32'(h_addr));
                    check({nm, " wdat held"}, csb_wdat_o, h_wdat);
                    hold = 1'b0;
                end
                if (chk == 1) begin
                    if (chk_ne) begin
                        check({nm, " start valid"}, 32'(csb_valid_o), 32'd1);
                        check({nm, " start count"}, 32'(cmd_count_o), 32'd0);
                    end else begin
                        check({nm, " empty start done"}, 32'(done_o), 32'd1);
                        check({nm, " empty start count"}, 32'(cmd_count_o), 32'(exp_count));
                        fin = 1'b1;
                    end
                end else if (chk == 2) begin
                    check({nm, " rdata_valid"}, 32'(rdata_valid_o), 32'(!cur.write));
                    if (!cur.write) check({nm, " rdata"}, rdata_o, rd);
                    check({nm, " cmd_count"}, 32'(cmd_count_o), 32'(exp_count));
                    if (cur.wait_intr) begin
                        check({nm, " idle in intr wait"}, 32'(csb_valid_o), 32'd0);
                        phase = 2; k = -1;
                        cur_intr = (cfg_intr_dly == -2) ? pick(-1, 6) : cfg_intr_dly;
                    end else if (chk_ne) begin
                        check({nm, " next issue"}, 32'(csb_valid_o), 32'd1);
                        phase = 0; bp = pick(cfg_bp, 3);
                    end else begin
                        check({nm, " done after resp"}, 32'(done_o), 32'd1);
                        fin = 1'b1;
                    end
                end else if (chk == 3) begin
                    if (chk_ne) begin
                        check({nm, " issue after intr"}, 32'(csb_valid_o), 32'd1);
                        phase = 0; bp = pick(cfg_bp, 3);
                    end else begin
                        check({nm, " done after intr"}, 32'(done_o), 32'd1);
                        fin = 1'b1;
                    end
                end
                chk = 0;
                if (!fin) begin
                    case (phase)
                        0: begin
                            if (cfg_noise) begin
                                csb_wr_complete_i = 1'($urandom);
                                csb_rdat_valid_i = 1'($urandom);
                                intr_i = 1'($urandom);
                            end
                            if (csb_valid_o) begin
                                if (bp > 0) begin
                                    bp--; hold = 1'b1;
                                    h_addr = csb_addr_o; h_wdat = csb_wdat_o;
                                end else if (exp_q.size() == 0) begin
                                    check({nm, " unexpected request"}, 32'(csb_valid_o), 32'd0);
                                    fin = 1'b1;
                                end else begin
                                    csb_ready_i = 1'b1;
                                    cur = exp_q.pop_front();
                                    check({nm, " req addr"}, 32'(csb_addr_o), 32'(cur.addr));
                                    check({nm, " req wdat"}, csb_wdat_o, cur.wdat);
                                    check({nm, " req write"}, 32'(csb_write_o), 32'(cur.write));
                                    check({nm, " nposted"}, 32'(csb_nposted_o), 32'(cur.write));
                                    phase = 1; cnt = pick(cfg_resp_dly, 4);
                                end
                            end
                        end
                        1: begin
                            check({nm, " one outstanding"}, 32'(csb_valid_o), 32'd0);
                            if (cfg_noise) intr_i = 1'($urandom);
                            if (cnt == 0) begin
                                if (cur.write) begin
                                    csb_wr_complete_i = 1'b1;
                                end else begin
                                    rd = cfg_rd_fixed ? cfg_rdat : $urandom;
                                    csb_rdat_i = rd; csb_rdat_valid_i = 1'b1;
                                end
                                if (exp_count < 65535) exp_count++;
                                chk = 2; chk_ne = (exp_q.size() != 0);
                            end else begin
                                cnt--;
                            end
                        end
                        default: begin
                            k++;
                            if (cfg_noise) begin
                                csb_wr_complete_i = 1'($urandom);
                                csb_rdat_valid_i = 1'($urandom);
                            end
                            if (cur_intr == k) begin
                                intr_i = 1'b1;
                                chk = 3; chk_ne = (exp_q.size() != 0);
                            end else if (timeout_cycles_i != 0 && k == int'(timeout_cycles_i) + 1) begin
                                exp_timeout = 1'b1;
                                check({nm, " timeout set"}, 32'(timeout_o), 32'd1);
                                check({nm, " timeout done"}, 32'(done_o), 32'd1);
                                check({nm, " timeout count"}, 32'(cmd_count_o), 32'(exp_count));
                                exp_q.delete();
                                fin = 1'b1;
                            end else begin
                                check({nm, " timeout level"}, 32'(timeout_o), 32'(exp_timeout));
                                check({nm, " no early done"}, 32'(done_o), 32'd0);
                            end
                        end
                    endcase
                    if (!fin && pend.size() > 0 && cmd_ready_o &&
                        $urandom_range(0, 99) < 32'(cfg_push_pct)) begin
                        cur_push(pend.pop_front());
                    end
                end
            end
        end
        check({nm, " busy in done"}, 32'(busy_o), 32'd1);
        tick();
        start_i = 1'b0; cmd_valid_i = 1'b0; csb_ready_i = 1'b0;
        csb_wr_complete_i = 1'b0; csb_rdat_valid_i = 1'b0; intr_i = 1'b0;
        check({nm, " done pulse ends"}, 32'(done_o), 32'd0);
        check({nm, " busy falls"}, 32'(busy_o), 32'd0);
        check({nm, " rdata_valid ends"}, 32'(rdata_valid_o), 32'd0);
    endtask

    task automatic cur_push(input cmd_t c);
        cmd_addr_i = c.addr; cmd_wdat_i = c.wdat;
        cmd_write_i = c.write; cmd_wait_intr_i = c.wait_intr;
        cmd_valid_i = 1'b1;
        exp_q.push_back(c);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick(); tick();
        check("rst csb_valid", 32'(csb_valid_o), 32'd0);
        check("rst cmd_ready", 32'(cmd_ready_o), 32'd0);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst count", 32'(cmd_count_o), 32'd0);
        check("rst rdata", rdata_o, 32'd0);
        rst_ni = 1'b1;
        #1 check("ready before first edge", 32'(cmd_ready_o), 32'd0);
        tick();
        check("ready after reset", 32'(cmd_ready_o), 32'd1);

        // Two writes
        push_idle(mk(16'h5000, 32'h1, 1'b1, 1'b0));
        push_idle(mk(16'h5004, 32'h2, 1'b1, 1'b0));
        cfg_resp_dly = 2;
        run_seq("two_wr");
        check("two_wr count", 32'(cmd_count_o), 32'd2);

        // Read
        cfg_resp_dly = 3; cfg_rd_fixed = 1'b1; cfg_rdat = 32'hCAFEF00D;
        push_idle(mk(16'h0004, 32'h0, 1'b0, 1'b0));
        run_seq("read");
        check("read rdata held", rdata_o, 32'hCAFEF00D);
        cfg_rd_fixed = 1'b0;

        // Interrupt wait, no limit
        cfg_resp_dly = 1; cfg_intr_dly = 10; timeout_cycles_i = 16'd0;
        push_idle(mk(16'h0010, 32'hA5A5, 1'b1, 1'b1));
        push_idle(mk(16'h0014, 32'h0, 1'b0, 1'b0));
        run_seq("intr");
        check("intr no timeout", 32'(timeout_o), 32'd0);

        // Interrupt in the same cycle as the limit expires
        cfg_intr_dly = 5; timeout_cycles_i = 16'd5;
        push_idle(mk(16'h0020, 32'h3, 1'b1, 1'b1));
        push_idle(mk(16'h0024, 32'h4, 1'b1, 1'b0));
        run_seq("intr_vs_tmo");
        check("intr wins", 32'(timeout_o), 32'd0);

        // Timeout with three commands behind the waiting one
        cfg_intr_dly = -1;
        push_idle(mk(16'h0030, 32'h5, 1'b1, 1'b1));
        for (int i = 0; i < 3; i++) push_idle(mk(16'(16'h0040 + i * 4), 32'(i), 1'b1, 1'b0));
        run_seq("timeout");
        check("timeout count", 32'(cmd_count_o), 32'd1);
        check("flush ready", 32'(cmd_ready_o), 32'd1);
        run_seq("after_flush");
        check("timeout sticky", 32'(timeout_o), 32'd1);
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        exp_timeout = 1'b0; exp_count = 0;
        check("clear timeout", 32'(timeout_o), 32'd0);

        // FIFO full, then mid-run push and backpressure
        timeout_cycles_i = 16'd0; cfg_bp = 4; cfg_push_pct = 100; cfg_resp_dly = 1;
        for (int i = 0; i < 8; i++) push_idle(mk(16'(16'h1000 + i * 4), $urandom, 1'($urandom), 1'b0));
        check("full ready", 32'(cmd_ready_o), 32'd0);
        cmd_addr_i = 16'h2000; cmd_wdat_i = 32'h99; cmd_write_i = 1'b1; cmd_wait_intr_i = 1'b0;
        cmd_valid_i = 1'b1; tick(); cmd_valid_i = 1'b0;
        check("full still", 32'(cmd_ready_o), 32'd0);
        pend.push_back(mk(16'h2000, 32'h99, 1'b1, 1'b0));
        run_seq("full");
        check("full count", 32'(cmd_count_o), 32'd9);
        cfg_bp = 0; cfg_push_pct = 0;

        // Clear while a write is outstanding
        push_idle(mk(16'h3000, 32'h7, 1'b1, 1'b0));
        push_idle(mk(16'h3004, 32'h8, 1'b1, 1'b0));
        start_i = 1'b1; tick(); start_i = 1'b0;
        check("clr issue", 32'(csb_valid_o), 32'd1);
        csb_ready_i = 1'b1; tick(); csb_ready_i = 1'b0;
        check("clr in resp", 32'(busy_o), 32'd1);
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        check("clr busy", 32'(busy_o), 32'd0);
        check("clr valid", 32'(csb_valid_o), 32'd0);
        check("clr count", 32'(cmd_count_o), 32'd0);
        csb_wr_complete_i = 1'b1; tick(); csb_wr_complete_i = 1'b0;
        check("late cpl count", 32'(cmd_count_o), 32'd0);
        check("late cpl done", 32'(done_o), 32'd0);
        exp_q.delete(); exp_count = 0;
        run_seq("clr empty");

        // Asynchronous reset during a read
        push_idle(mk(16'h4000, 32'h0, 1'b0, 1'b0));
        start_i = 1'b1; tick(); start_i = 1'b0;
        csb_ready_i = 1'b1; tick(); csb_ready_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1 check("arst busy", 32'(busy_o), 32'd0);
        check("arst valid", 32'(csb_valid_o), 32'd0);
        tick(); rst_ni = 1'b1;
        csb_rdat_i = 32'h12345678; csb_rdat_valid_i = 1'b1; tick(); csb_rdat_valid_i = 1'b0;
        check("arst late rdata", 32'(rdata_valid_o), 32'd0);
        check("arst rdata", rdata_o, 32'd0);
        exp_q.delete(); exp_count = 0;

        // Randomized runs
        cfg_resp_dly = -1; cfg_bp = -1; cfg_intr_dly = -2; cfg_noise = 1'b1; cfg_push_pct = 30;
        for (int r = 0; r < 25; r++) begin
            int n;
            timeout_cycles_i = ($urandom_range(0, 1) == 1) ? 16'd40 : 16'd0;
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) push_idle(rnd_cmd());
            n = int'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) pend.push_back(rnd_cmd());
            run_seq("rnd");
        end
        cfg_push_pct = 100;
        for (int r = 0; r < 10 && (exp_q.size() != 0 || pend.size() != 0); r++) run_seq("drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
